// File: rtl/xt_hb_rw_arbiter_if.sv
// HB arbiter bus bundle: per-master read/write requests and finishes in, grants and status out.
// The slave modport is the arbiter side; the master modport is the requester/controller side.
interface xt_hb_rw_arbiter_if #(
    parameter int MASTER_NUM = 2
);
    logic [MASTER_NUM-1:0] read_req;
    logic [MASTER_NUM-1:0] write_req;
    logic                  read_finish;
    logic                  write_finish;
    logic [MASTER_NUM-1:0] read_grant;
    logic [MASTER_NUM-1:0] write_grant;
    logic                  read_busy;
    logic                  write_busy;
    logic                  read_timeout;
    logic                  write_timeout;

    modport master (
        output read_req, write_req, read_finish, write_finish,
        input  read_grant, write_grant, read_busy, write_busy, read_timeout, write_timeout
    );

    modport slave (
        input  read_req, write_req, read_finish, write_finish,
        output read_grant, write_grant, read_busy, write_busy, read_timeout, write_timeout
    );
endinterface

// File: rtl/xt_hb_rw_arbiter.sv
// Full-duplex round-robin HB arbiter: independent read/write channels with bounded bursts and a
// stall watchdog. Define XT_HB_ARB_CORE_PRIO_EN to give master 0 absolute priority and unbounded bursts.
module xt_hb_rw_arbiter #(
    parameter int MASTER_NUM = 2,
    parameter int MAX_HOLD   = 4,
    parameter int TIMEOUT    = 255
) (
    input logic              clk,
    input logic              rst_sync,
    xt_hb_rw_arbiter_if.slave bus
);
    localparam int unsigned MN = MASTER_NUM;
    localparam int PW = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, GRANT} state_t;

    logic [MASTER_NUM-1:0] req_c [2];
    logic                  fin_c [2];

    // Channel 0 is read, channel 1 is write; both run the same logic with no shared state.
    always_comb begin
        req_c[0] = bus.read_req;
        req_c[1] = bus.write_req;
        fin_c[0] = bus.read_finish;
        fin_c[1] = bus.write_finish;
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_t                state_q;
        logic [MASTER_NUM-1:0] grant_q;
        logic [PW-1:0]         ptr_q;
        logic [PW-1:0]         gidx_q;
        logic [HW-1:0]         hcnt_q;
        logic [WW-1:0]         wcnt_q;
        logic                  timeout_q;

        logic [PW-1:0] sel;
        logic [PW-1:0] idx;
        logic          sel_vld;
        logic [PW-1:0] ptr_nxt;
        logic          req_g;
        logic          hold_more;
        logic          burst_more;
        logic          wd_expired;

        always_comb begin
            sel     = '0;
            idx     = '0;
            sel_vld = 1'b0;
            for (int unsigned i = 0; i < MN; i++) begin
                idx = PW'((32'(ptr_q) + i) % MN);
                if (!sel_vld && req_c[c][idx]) begin
                    sel     = idx;
                    sel_vld = 1'b1;
                end
            end
`ifdef XT_HB_ARB_CORE_PRIO_EN
            if (req_c[c][0]) begin
                sel     = '0;
                sel_vld = 1'b1;
            end
`endif
            ptr_nxt    = (32'(gidx_q) == MN - 1) ? '0 : gidx_q + 1'b1;
            req_g      = |(grant_q & req_c[c]);
            hold_more  = (32'(hcnt_q) + 1) < 32'(MAX_HOLD);
            wd_expired = (wcnt_q == WW'(TIMEOUT - 1));
`ifdef XT_HB_ARB_CORE_PRIO_EN
            burst_more = hold_more || (gidx_q == '0);
`else
            burst_more = hold_more;
`endif
        end

        always_ff @(posedge clk) begin
            if (rst_sync) begin
                state_q   <= IDLE;
                grant_q   <= '0;
                ptr_q     <= '0;
                gidx_q    <= '0;
                hcnt_q    <= '0;
                wcnt_q    <= '0;
                timeout_q <= 1'b0;
            end else begin
                timeout_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (sel_vld) begin
                            state_q <= GRANT;
                            grant_q <= MASTER_NUM'(1) << sel;
                            gidx_q  <= sel;
                            hcnt_q  <= '0;
                            wcnt_q  <= '0;
                        end
                    end
                    GRANT: begin
                        // A finish always beats the watchdog in the same cycle.
                        if (!fin_c[c] && wd_expired) begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            ptr_q     <= '0;
                            timeout_q <= 1'b1;
                        end else if (fin_c[c]) begin
                            if (burst_more) begin
                                if (hold_more) hcnt_q <= hcnt_q + 1'b1;
                                wcnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                grant_q <= '0;
                                ptr_q   <= ptr_nxt;
                            end
                        end else if (!req_g) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            ptr_q   <= ptr_nxt;
                        end else if (!wd_expired) begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.read_grant    = g_ch[0].grant_q;
    assign bus.write_grant   = g_ch[1].grant_q;
    assign bus.read_busy     = (g_ch[0].state_q == GRANT);
    assign bus.write_busy    = (g_ch[1].state_q == GRANT);
    assign bus.read_timeout  = g_ch[0].timeout_q;
    assign bus.write_timeout = g_ch[1].timeout_q;
endmodule

// File: tb/tb_xt_hb_rw_arbiter.sv
// Scoreboard bench for xt_hb_rw_arbiter: a transaction-level ownership model predicts each cycle's
// grants/busy/timeout, a separate monitor pops and compares #1 after every clock edge.
module tb_xt_hb_rw_arbiter;
    localparam int MN = 3;
    localparam int MH = 3;
    localparam int TO = 8;
`ifdef XT_HB_ARB_CORE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        logic [MN-1:0] rg;
        logic [MN-1:0] wg;
        logic          rb;
        logic          wb;
        logic          rt;
        logic          wt;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_sync;
    xt_hb_rw_arbiter_if #(.MASTER_NUM(MN)) bus ();

    xt_hb_rw_arbiter #(.MASTER_NUM(MN), .MAX_HOLD(MH), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: who owns each channel, how many finishes and idle-waits it has used, and where the
    // next round-robin search starts.
    int owner  [2];
    int ptr    [2];
    int nfin   [2];
    int waited [2];

    function automatic int pick(logic [MN-1:0] r, int p);
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < MN; k++)
            if (r[(p + k) % MN]) return (p + k) % MN;
        return -1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            owner[c] = -1; ptr[c] = 0; nfin[c] = 0; waited[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input logic [MN-1:0] r, input logic f, output bit to);
        to = 1'b0;
        if (owner[c] < 0) begin
            owner[c] = pick(r, ptr[c]);
            nfin[c] = 0;
            waited[c] = 0;
        end else if (!f && waited[c] == TO - 1) begin
            owner[c] = -1; ptr[c] = 0; to = 1'b1;
        end else if (f) begin
            nfin[c]++;
            if ((PRIO && owner[c] == 0) || nfin[c] < MH) waited[c] = 0;
            else begin ptr[c] = (owner[c] + 1) % MN; owner[c] = -1; end
        end else if (!r[owner[c]]) begin
            ptr[c] = (owner[c] + 1) % MN; owner[c] = -1;
        end else begin
            waited[c]++;
        end
    endtask

    function automatic logic [MN-1:0] onehot(int o);
        logic [MN-1:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input int cyc, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor: outputs are registered, so sample just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("read_grant",    e.cyc, 32'(bus.read_grant),    32'(e.rg));
                chk("write_grant",   e.cyc, 32'(bus.write_grant),   32'(e.wg));
                chk("read_busy",     e.cyc, 32'(bus.read_busy),     32'(e.rb));
                chk("write_busy",    e.cyc, 32'(bus.write_busy),    32'(e.wb));
                chk("read_timeout",  e.cyc, 32'(bus.read_timeout),  32'(e.rt));
                chk("write_timeout", e.cyc, 32'(bus.write_timeout), 32'(e.wt));
            end
        end
    end

    // Driver: choose inputs per phase, advance the model, queue the expected post-edge outputs.
    initial begin
        logic [MN-1:0] rq, wq;
        logic          rf, wf, rs;
        bit            rto, wto;
        exp_t          e;
        rst_sync = 1'b1;
        bus.read_req = '0; bus.write_req = '0;
        bus.read_finish = 1'b0; bus.write_finish = 1'b0;
        rq = '0; wq = '0;
        model_reset();
        for (int cyc = 0; cyc < 2400; cyc++) begin
            @(negedge clk);
            rs = 1'b0;
            if (cyc < 2) begin
                rs = 1'b1;
                rq = MN'($urandom); wq = MN'($urandom);
                rf = 1'($urandom); wf = 1'($urandom);
            end else if (cyc < 62) begin
                // bursts: all masters read, finishing every granted cycle; one writer alone
                rq = '1; wq = '0; wq[MN-1] = 1'b1;
                rf = (owner[0] >= 0); wf = (owner[1] >= 0);
            end else if (cyc < 122) begin
                // stalls: nobody finishes, watchdog must fire repeatedly
                rq = '1;
                if ($urandom_range(7) == 0) wq = MN'($urandom);
                rf = 1'b0; wf = 1'b0;
            end else if (cyc < 242) begin
                // withdrawals: requests drop often, finishes are rare
                for (int i = 0; i < MN; i++) begin
                    if ($urandom_range(3) == 0) rq[i] = ~rq[i];
                    if ($urandom_range(3) == 0) wq[i] = ~wq[i];
                end
                rf = ($urandom_range(7) == 0); wf = ($urandom_range(7) == 0);
            end else begin
                for (int i = 0; i < MN; i++) begin
                    if ($urandom_range(5) == 0) rq[i] = ~rq[i];
                    if ($urandom_range(5) == 0) wq[i] = ~wq[i];
                end
                rf = ($urandom_range(2) == 0); wf = ($urandom_range(2) == 0);
                rs = ($urandom_range(149) == 0);
            end
            rst_sync = rs;
            bus.read_req = rq; bus.write_req = wq;
            bus.read_finish = rf; bus.write_finish = wf;
            rto = 1'b0; wto = 1'b0;
            if (rs) model_reset();
            else begin
                model_step(0, rq, rf, rto);
                model_step(1, wq, wf, wto);
            end
            e.rg = onehot(owner[0]); e.wg = onehot(owner[1]);
            e.rb = (owner[0] >= 0);  e.wb = (owner[1] >= 0);
            e.rt = rto; e.wt = wto; e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #3;
        chk("scoreboard_drained", -1, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xt_hb_rw_arbiter.md
Name: xt_hb_rw_arbiter

Overview:
- Round-robin arbiter for the high-speed bus (HB), with independent read and write channels, so reads and writes run full duplex.
- Each channel grants one master at a time, holds the grant until the transaction finishes, and lets a master keep the channel for a bounded burst of back-to-back accesses.
- A watchdog force-releases any grant that stalls, then resets the channel's priority pointer to master 0.
- Sits inside the HB controller between master request bits and the address/data multiplexers.

Parameters:
- MASTER_NUM, 2, number of HB masters (≥1); master 0 is the core.
- MAX_HOLD, 4, consecutive finished transactions one master may complete per grant before rotation is forced (≥1).
- TIMEOUT, 255, cycles a grant may stay active without the matching finish before forced release (≥2).

Ports:
- clk  input  1  system clock.
- rst_sync  input  1  synchronous reset, active-high.
- read_req  input  MASTER_NUM  per-master read request, level, held until served.
- write_req  input  MASTER_NUM  per-master write request, level, held until served.
- read_finish  input  1  granted read completes this cycle (OR of device read_finish masked by selected device).
- write_finish  input  1  granted write completes this cycle.
- read_grant  output  MASTER_NUM  one-hot (or zero) read grant, registered.
- write_grant  output  MASTER_NUM  one-hot (or zero) write grant, registered.
- read_busy  output  1  read channel in GRANT state.
- write_busy  output  1  write channel in GRANT state.
- read_timeout  output  1  one-cycle pulse on forced read release.
- write_timeout  output  1  one-cycle pulse on forced write release.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_sync, synchronous, active-high.
- Reset values: all grants 0, busy 0, timeout 0, both pointers 0, hold counters 0, watchdog counters 0.
- Read and write channels are identical, independent instances of the logic below. There is no interaction between them; one master may hold both channels at once.
- Per-channel state: FSM {IDLE, GRANT}; pointer ptr (width max(1, clog2(MASTER_NUM))); hold counter hcnt; watchdog counter wcnt.
- IDLE:
  - If any req bit is set, select the first requesting master scanning ptr, ptr+1, … modulo MASTER_NUM.
  - Next cycle: grant[sel]=1, busy=1, state GRANT, hcnt=0, wcnt=0.
  - Grant latency is exactly 1 cycle from req rising in IDLE. No req means no change.
- GRANT, evaluated each cycle with g = granted master; rules in priority order:
  1. wcnt == TIMEOUT-1 and no finish: next cycle grant=0, busy=0, state IDLE, ptr=0, timeout pulse=1.
  2. finish=1:
     - hcnt+1 < MAX_HOLD: stay in GRANT, hcnt+1, wcnt=0 (burst continuation). If req[g] is low, the next cycle's rule 3 releases.
     - hcnt+1 == MAX_HOLD: release; next cycle grant=0, state IDLE, ptr=(g+1) mod MASTER_NUM.
  3. req[g]=0 with no finish (request withdrawn or burst ended): release next cycle, ptr=(g+1) mod MASTER_NUM.
  4. Otherwise hold the grant and wcnt+1.
- Release always passes through one IDLE cycle with grant=0. Rotation therefore costs one bubble; the HB stalls the denied master meanwhile.
- Finish and req drop in the same cycle: rule 2 applies first; the next cycle's rule 3 releases. A finish in the same cycle as a timeout counts as finish (no timeout).
- Grants never change while busy except on the release rules above. A grant never goes to a master whose req is low at selection time.
- rst_sync mid-transaction: all state returns to reset values next cycle; no timeout pulse.
- MASTER_NUM=1: ptr is constant 0; rotation degenerates to re-grant after the IDLE bubble.
- wcnt saturates at TIMEOUT-1; width clog2(TIMEOUT).

Optional Feature:
- Macro XT_HB_ARB_CORE_PRIO_EN.
- Defined: in IDLE, a set req[0] always wins regardless of ptr. Master 0's bursts ignore MAX_HOLD and end only on req drop or timeout. ptr still advances after other masters' releases.
- Undefined: pure round-robin as specified, master 0 treated like others.

Test Plan:
- Reset: rst_sync=1 for 2 cycles, random reqs → all grants/busy/timeout 0 throughout reset and for the cycle it is released.
- Round-robin, MASTER_NUM=2, MAX_HOLD=1, read_req=2'b11 continuous, read_finish pulsed 1 cycle after each grant → read_grant sequence 01,00,10,00,01…
- Burst, MAX_HOLD=4, master 1 alone, write_finish every cycle → write_grant=10 for 4 finishes, then 1 IDLE cycle, then 10 again.
- Full duplex: read_req=01 and write_req=10 in the same cycle → next cycle read_grant=01 and write_grant=10 simultaneously, with read_busy=write_busy=1.
- Timeout, TIMEOUT=8: grant master 1 read and never assert read_finish → after 8 granted cycles, read_grant=0 and read_timeout pulses one cycle; with both requesting, next grant goes to master 0 (ptr=0).
- Withdraw: grant master 0, then drop req[0] without finish → grant released next cycle; with req[1]=1, master 1 is granted the following cycle. With XT_HB_ARB_CORE_PRIO_EN, req=11 after any release → grant 01.
